// File: rtl/sprite_pkg.sv
// Shared definitions for the maze sprite movers and the maze drawer:
// direction encoding, button bit positions and default track coordinates.
package sprite_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // Button vector is {U,D,L,R}
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;

    localparam int TRACK_MIN = 50;
    localparam int TRACK_MID = 220;
    localparam int TRACK_MAX = 390;

    // Several buttons held at once resolve as U > D > L > R.
    function automatic dir_t btn_to_dir(input logic [3:0] btn);
        dir_t d;
        d = DIR_NONE;
        if (btn[BTN_U]) begin
            d = DIR_UP;
        end else if (btn[BTN_D]) begin
            d = DIR_DOWN;
        end else if (btn[BTN_L]) begin
            d = DIR_LEFT;
        end else if (btn[BTN_R]) begin
            d = DIR_RIGHT;
        end
        return d;
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running move-rate divider: one-cycle tick every DIV clocks.
// Shared by the player and ghost movers.
module move_tick_gen #(
    parameter int DIV = 10_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign o_tick = (cnt == LAST);

endmodule

// File: rtl/sprite_mover.sv
// Player sprite position controller: track-constrained stepping on a move tick,
// queued turns for cornering, soft clear and a strobe-aligned pixel hit test.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int X_INIT    = 50,
    parameter int Y_INIT    = 50,
    parameter int X_MIN     = TRACK_MIN,
    parameter int X_MID     = TRACK_MID,
    parameter int X_MAX     = TRACK_MAX,
    parameter int Y_MIN     = TRACK_MIN,
    parameter int Y_MID     = TRACK_MID,
    parameter int Y_MAX     = TRACK_MAX,
    parameter int STEP      = 10,
    parameter int TICK_DIV  = 10_000_000,
    parameter int HALF      = 6,
    parameter int CONT_MODE = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [3:0]     i_btn,
    input  logic           i_clear,
    input  logic           i_pix_stb,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    output logic [X_W-1:0] o_xpos,
    output logic [Y_W-1:0] o_ypos,
    output logic [2:0]     o_dir,
    output logic           o_moving,
    output logic           o_blocked,
    output logic           o_hit
);

    localparam logic [X_W-1:0] XT_MIN  = X_W'(X_MIN);
    localparam logic [X_W-1:0] XT_MID  = X_W'(X_MID);
    localparam logic [X_W-1:0] XT_MAX  = X_W'(X_MAX);
    localparam logic [X_W-1:0] XT_INIT = X_W'(X_INIT);
    localparam logic [X_W-1:0] XT_STEP = X_W'(STEP);
    localparam logic [Y_W-1:0] YT_MIN  = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] YT_MID  = Y_W'(Y_MID);
    localparam logic [Y_W-1:0] YT_MAX  = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] YT_INIT = Y_W'(Y_INIT);
    localparam logic [Y_W-1:0] YT_STEP = Y_W'(STEP);

    // One bit wider so limit checks and hit bounds cannot wrap.
    localparam logic [X_W:0] XW_MAX      = (X_W+1)'(X_MAX);
    localparam logic [X_W:0] XW_LEFT_LIM = (X_W+1)'(X_MIN + STEP);
    localparam logic [X_W:0] XW_STEP     = (X_W+1)'(STEP);
    localparam logic [X_W:0] XW_HALF     = (X_W+1)'(HALF);
    localparam logic [Y_W:0] YW_MAX      = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W:0] YW_UP_LIM   = (Y_W+1)'(Y_MIN + STEP);
    localparam logic [Y_W:0] YW_STEP     = (Y_W+1)'(STEP);
    localparam logic [Y_W:0] YW_HALF     = (Y_W+1)'(HALF);

    logic [3:0]     btn_meta_p1;
    logic [3:0]     btn_sync_p2;
    logic           tick;
    logic [X_W-1:0] xpos, xpos_n;
    logic [Y_W-1:0] ypos, ypos_n;
    dir_t           dir, dir_n;
    dir_t           pending, pending_n;
    dir_t           held_dir, eff_dir;
    logic           accept, eff_ok;
    logic           blocked, blocked_n;
    logic           hit, hit_n;

    function automatic logic move_legal(input dir_t d, input logic [X_W-1:0] x,
                                        input logic [Y_W-1:0] y);
        logic         on_vert;
        logic         on_horz;
        logic [X_W:0] xw;
        logic [Y_W:0] yw;
        logic         ok;
        xw      = {1'b0, x};
        yw      = {1'b0, y};
        on_vert = (x == XT_MIN) || (x == XT_MID) || (x == XT_MAX);
        on_horz = (y == YT_MIN) || (y == YT_MID) || (y == YT_MAX);
        case (d)
            DIR_UP:    ok = on_vert && (yw >= YW_UP_LIM);
            DIR_DOWN:  ok = on_vert && ((yw + YW_STEP) <= YW_MAX);
            DIR_LEFT:  ok = on_horz && (xw >= XW_LEFT_LIM);
            DIR_RIGHT: ok = on_horz && ((xw + XW_STEP) <= XW_MAX);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    move_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta_p1 <= '0;
            btn_sync_p2 <= '0;
        end else begin
            btn_meta_p1 <= i_btn;
            btn_sync_p2 <= btn_meta_p1;
        end
    end

    always_comb begin
        held_dir  = btn_to_dir(btn_sync_p2);
        accept    = tick && (pending != DIR_NONE) && move_legal(pending, xpos, ypos);
        eff_dir   = accept ? pending : dir;
        eff_ok    = move_legal(eff_dir, xpos, ypos);
        xpos_n    = xpos;
        ypos_n    = ypos;
        dir_n     = dir;
        pending_n = pending;
        blocked_n = 1'b0;
        if (i_clear) begin
            xpos_n    = XT_INIT;
            ypos_n    = YT_INIT;
            dir_n     = DIR_NONE;
            pending_n = DIR_NONE;
        end else begin
            if (tick) begin
                if (eff_ok) begin
                    dir_n = eff_dir;
                    case (eff_dir)
                        DIR_UP:    ypos_n = ypos - YT_STEP;
                        DIR_DOWN:  ypos_n = ypos + YT_STEP;
                        DIR_LEFT:  xpos_n = xpos - XT_STEP;
                        DIR_RIGHT: xpos_n = xpos + XT_STEP;
                        default:   ;
                    endcase
                end else begin
                    // An illegal queued turn stays queued; only a stalled current move reports.
                    dir_n     = DIR_NONE;
                    blocked_n = (eff_dir != DIR_NONE);
                end
                if (CONT_MODE == 0) begin
                    dir_n = DIR_NONE;
                end
                if (accept) begin
                    pending_n = DIR_NONE;
                end
            end
            if (CONT_MODE != 0) begin
                if (held_dir != DIR_NONE) begin
                    pending_n = held_dir;
                end
            end else begin
                pending_n = held_dir;
            end
        end
    end

    always_comb begin
        hit_n = (({1'b0, i_x} + XW_HALF) > {1'b0, xpos}) &&
                ({1'b0, i_x} < ({1'b0, xpos} + XW_HALF)) &&
                (({1'b0, i_y} + YW_HALF) > {1'b0, ypos}) &&
                ({1'b0, i_y} < ({1'b0, ypos} + YW_HALF));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xpos    <= XT_INIT;
            ypos    <= YT_INIT;
            dir     <= DIR_NONE;
            pending <= DIR_NONE;
            blocked <= 1'b0;
            hit     <= 1'b0;
        end else begin
            xpos    <= xpos_n;
            ypos    <= ypos_n;
            dir     <= dir_n;
            pending <= pending_n;
            blocked <= blocked_n;
            // Hit uses the position before any same-cycle move.
            if (i_pix_stb) begin
                hit <= hit_n;
            end
        end
    end

    assign o_xpos    = xpos;
    assign o_ypos    = ypos;
    assign o_dir     = dir;
    assign o_moving  = (dir != DIR_NONE);
    assign o_blocked = blocked;
    assign o_hit     = hit;

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised player-sprite position controller for the VGA maze display.
- Successor to the fixed-step, button-held movement logic. Adds:
  - generic bounds, step and tick rate;
  - maze-track legality checks;
  - latched continuous motion and queued turns (cornering);
  - soft clear;
  - registered pixel hit test aligned to the pixel strobe.
- Sits between the board buttons / vga640x480 timing and the colour mux in the display top.

Parameters:
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- X_INIT / Y_INIT, 50 / 50, start and clear position
- X_MIN / X_MID / X_MAX, 50 / 220 / 390, vertical track x coordinates; also horizontal bounds
- Y_MIN / Y_MID / Y_MAX, 50 / 220 / 390, horizontal track y coordinates; also vertical bounds
- STEP, 10, pixels moved per tick
- TICK_DIV, 10_000_000, clk cycles per move tick (10 Hz at 100 MHz)
- HALF, 6, sprite half-size in pixels
- CONT_MODE, 1, 1 = keep moving in latched direction; 0 = move only while button held

Ports:
- i_clk  in  1  system clock, 100 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_btn  in  4  raw buttons {U,D,L,R}, asynchronous
- i_clear  in  1  synchronous soft reset to X_INIT/Y_INIT, level
- i_pix_stb  in  1  pixel strobe, 1-cycle pulse
- i_x  in  X_W  current scan x
- i_y  in  Y_W  current scan y
- o_xpos  out  X_W  sprite centre x
- o_ypos  out  Y_W  sprite centre y
- o_dir  out  3  current direction (NONE/UP/DOWN/LEFT/RIGHT)
- o_moving  out  1  o_dir != NONE
- o_blocked  out  1  1-cycle pulse: move refused on a tick
- o_hit  out  1  scan pixel inside sprite, registered

Behaviour:
- Reset (async, i_rst_n low) values:
  - o_xpos=X_INIT, o_ypos=Y_INIT
  - o_dir=NONE, pending=NONE
  - o_blocked=0, o_hit=0
  - tick counter=0, synchroniser flops=0
- Buttons:
  - 2-flop synchroniser per bit, so 2-cycle input latency.
  - Priority when several are held: U>D>L>R.
- Tick: counter runs 0..TICK_DIV-1 and pulses tick when it wraps. It free-runs and is unaffected by i_clear.
- Pending direction:
  - CONT_MODE=1: any held synced button overwrites pending every cycle; pending persists after release.
  - CONT_MODE=0: pending = prioritised held button, or NONE when nothing is held.
- Legality, checked against the current registered position:
  - UP: x ∈ {X_MIN,X_MID,X_MAX} and y >= Y_MIN+STEP
  - DOWN: x on a vertical track and y+STEP <= Y_MAX
  - LEFT: y ∈ {Y_MIN,Y_MID,Y_MAX} and x >= X_MIN+STEP
  - RIGHT: y on a horizontal track and x+STEP <= X_MAX
  - Arithmetic is done one bit wider, so there is no underflow or overflow.
- On tick, in order:
  1. If pending != NONE and pending is legal: dir <= pending, pending <= NONE.
  2. Effective dir = the new dir. If it is legal, step position by STEP.
  3. If the effective dir is not NONE and not legal: dir <= NONE and o_blocked pulses. A queued pending direction that is illegal stays queued without pulsing.
  4. CONT_MODE=0 only: dir <= NONE after the step; pending is re-evaluated every tick.
- Position is never driven outside [MIN,MAX] and only changes on a tick.
- i_clear high:
  - position, dir and pending go to their init values; o_blocked=0.
  - It takes priority over a tick in the same cycle; that tick is discarded.
- Hit test:
  - Evaluated only on cycles where i_pix_stb=1.
  - hit = (i_x+HALF > xpos) & (i_x < xpos+HALF) & (i_y+HALF > ypos) & (i_y < ypos+HALF), computed one bit wider.
  - o_hit is registered, 1-cycle latency, held between strobes.
  - It uses the pre-update position if a move occurs in the same cycle.
- Reset mid-motion: all state returns to reset values immediately; the tick phase restarts at 0.

Decomposition:
- Shared package sprite_pkg:
  - direction encoding: DIR_NONE=0, DIR_UP=1, DIR_DOWN=2, DIR_LEFT=3, DIR_RIGHT=4
  - button bit indices
  - default track coordinates, which the maze drawer also uses
- Sub-module move_tick_gen: parameter DIV, ports i_clk/i_rst_n/o_tick. It is reusable by the future ghost mover.

Test Plan:
- Reset: assert i_rst_n=0 mid-run → o_xpos=50, o_ypos=50, o_dir=NONE, o_hit=0 asynchronously; stays there after release with no buttons.
- Continuous run (TICK_DIV=4, CONT_MODE=1): pulse R for 3 cycles → xpos 60, 70, … 390 on successive ticks. Next tick: o_blocked pulse, o_dir=NONE, xpos stays 390.
- Cornering: moving RIGHT at y=50, press D at x=100 → still RIGHT until x=220. Next tick: dir=DOWN, x=220, y=60.
- Illegal move: at (50,50) press U → no move, no o_blocked, pending held. Then press D → y=60.
- Clear vs tick: moving at (120,50), i_clear coincident with tick → (50,50), dir=NONE, o_blocked=0.
- Hit edges at (50,50), i_y=50, i_pix_stb pulsed → o_hit one cycle later is 0/1/1/0 for i_x=44/45/55/56. No strobe → o_hit holds.
